// File: rtl/dll_rx_acknak_if.sv
// Link-side bundle for the DLL receive ACK/NAK scheduler: received-TLP
// status in, TLP accept pulse out, and the DLLP request/ready handshake.
interface dll_rx_acknak_if;
  logic        tlp_valid;
  logic [11:0] tlp_seq;
  logic        tlp_crc_ok;
  logic        tlp_accept;
  logic        dllp_valid;
  logic        dllp_ready;
  logic        dllp_nak;
  logic [11:0] dllp_seq;

  modport master (
    output tlp_valid, tlp_seq, tlp_crc_ok, dllp_ready,
    input  tlp_accept, dllp_valid, dllp_nak, dllp_seq
  );
  modport slave (
    input  tlp_valid, tlp_seq, tlp_crc_ok, dllp_ready,
    output tlp_accept, dllp_valid, dllp_nak, dllp_seq
  );
endinterface

// File: rtl/dll_rx_acknak.sv
// Receiver-side DLL ACK/NAK scheduler: checks TLP sequence/LCRC against NRS and
// issues ACK/NAK DLLPs. Define RX_STATS_EN to add saturating BAD/DUP/NAK counters.
module dll_rx_acknak #(
  parameter int ACK_LATENCY  = 64,
  parameter int ACK_COALESCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  dll_rx_acknak_if.slave   bus,
  output logic [11:0]      nrs
`ifdef RX_STATS_EN
  ,
  output logic [15:0]      stat_bad,
  output logic [15:0]      stat_dup,
  output logic [15:0]      stat_nak
`endif
);
  localparam int TW = (ACK_LATENCY > 2) ? $clog2(ACK_LATENCY) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_LATENCY - 1);
  localparam logic [7:0]    COAL     = 8'(ACK_COALESCE);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;

  logic          nak_sched, nak_pend, ack_force;
  logic [7:0]    pend_cnt;
  logic [TW-1:0] ack_tmr;

  // Distance back from NRS: 0 = expected, upper half = ahead of NRS (lost TLP).
  logic [11:0] d;
  logic is_bad, is_good, is_dup, is_ahead, issue;

  assign d        = nrs - bus.tlp_seq;
  assign is_bad   = bus.tlp_valid && !bus.tlp_crc_ok;
  assign is_good  = bus.tlp_valid &&  bus.tlp_crc_ok && (d == 12'd0);
  assign is_dup   = bus.tlp_valid &&  bus.tlp_crc_ok && (d != 12'd0) && !d[11];
  assign is_ahead = bus.tlp_valid &&  bus.tlp_crc_ok && d[11];

  assign issue = (state == IDLE) &&
                 (nak_pend || ack_force || (pend_cnt >= COAL) ||
                  ((ack_tmr == TMR_LAST) && (pend_cnt != 8'd0)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (issue)          state_nxt = HOLD;
      HOLD: if (bus.dllp_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.dllp_valid = (state == HOLD);
  end

  // Issue clears first; the same-cycle TLP event is assigned later so it wins
  // and stays pending for the next DLLP.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tlp_accept <= 1'b0;
      bus.dllp_nak   <= 1'b0;
      bus.dllp_seq   <= 12'd0;
      nrs            <= 12'd0;
      nak_sched      <= 1'b0;
      nak_pend       <= 1'b0;
      ack_force      <= 1'b0;
      pend_cnt       <= 8'd0;
      ack_tmr        <= '0;
    end else begin
      bus.tlp_accept <= is_good;
      if (issue) begin
        bus.dllp_nak <= nak_pend;
        bus.dllp_seq <= nrs - 12'd1;
        nak_pend     <= 1'b0;
        ack_force    <= 1'b0;
        pend_cnt     <= 8'd0;
        ack_tmr      <= '0;
      end else if ((state == IDLE) && (pend_cnt != 8'd0)) begin
        ack_tmr <= ack_tmr + TW'(1);
      end
      if (is_good) begin
        nrs       <= nrs + 12'd1;
        nak_sched <= 1'b0;
        if (issue)                 pend_cnt <= 8'd1;
        else if (pend_cnt != 8'hFF) pend_cnt <= pend_cnt + 8'd1;
      end
      if (is_dup) ack_force <= 1'b1;
      if ((is_bad || is_ahead) && !nak_sched) begin
        nak_pend  <= 1'b1;
        nak_sched <= 1'b1;
      end
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_bad <= 16'd0;
      stat_dup <= 16'd0;
      stat_nak <= 16'd0;
    end else begin
      if (is_bad && stat_bad != 16'hFFFF)                stat_bad <= stat_bad + 16'd1;
      if (is_dup && stat_dup != 16'hFFFF)                stat_dup <= stat_dup + 16'd1;
      if (issue && nak_pend && stat_nak != 16'hFFFF)     stat_nak <= stat_nak + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dll_rx_acknak.sv
// Bench for dll_rx_acknak: directed scenarios plus randomized traffic against
// a cycle-level reference model of the receive ACK/NAK rules.
module tb_dll_rx_acknak;
  localparam int LAT  = 64;
  localparam int COAL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] nrs;
  dll_rx_acknak_if bus();
`ifdef RX_STATS_EN
  logic [15:0] stat_bad, stat_dup, stat_nak;
`endif

  dll_rx_acknak #(.ACK_LATENCY(LAT), .ACK_COALESCE(COAL)) dut (
    .clk(clk), .rst(rst), .bus(bus), .nrs(nrs)
`ifdef RX_STATS_EN
    , .stat_bad(stat_bad), .stat_dup(stat_dup), .stat_nak(stat_nak)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_nrs, m_pend, m_tmr, m_seq;
  bit m_sched, m_npend, m_force, m_hold, m_nak, m_acc;

  // Advance model by one edge from current inputs, then step the DUT clock.
  task automatic tick();
    bit iss;
    int d;
    if (rst) begin
      m_nrs = 0; m_pend = 0; m_tmr = 0; m_seq = 0;
      m_sched = 0; m_npend = 0; m_force = 0; m_hold = 0; m_nak = 0; m_acc = 0;
    end else begin
      iss = !m_hold && (m_npend || m_force || m_pend >= COAL || (m_tmr == LAT-1 && m_pend > 0));
      m_acc = 0;
      if (m_hold) begin
        if (bus.dllp_ready) m_hold = 0;
      end else if (iss) begin
        m_hold = 1; m_nak = m_npend; m_seq = (m_nrs + 4095) % 4096;
        m_npend = 0; m_force = 0; m_pend = 0; m_tmr = 0;
      end else if (m_pend > 0) begin
        m_tmr++;
      end
      if (bus.tlp_valid) begin
        d = (m_nrs - int'(bus.tlp_seq) + 4096) % 4096;
        if (!bus.tlp_crc_ok || d >= 2048) begin
          if (!m_sched) begin m_npend = 1; m_sched = 1; end
        end else if (d == 0) begin
          m_acc = 1; m_nrs = (m_nrs + 1) % 4096; m_sched = 0;
          if (m_pend < 255) m_pend++;
        end else begin
          m_force = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int seq, input bit crc);
    bus.tlp_valid = 1'b1; bus.tlp_seq = 12'(seq); bus.tlp_crc_ok = crc;
    tick();
    bus.tlp_valid = 1'b0;
  endtask

  task automatic wait_dllp(input int maxc, output bit found, output int n);
    n = 0;
    while (!bus.dllp_valid && n < maxc) begin tick(); n++; end
    found = bus.dllp_valid;
  endtask

  task automatic reset_and_fill(input int cnt);
    bus.dllp_ready = 1'b1;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < cnt; i++) send(i, 1'b1);
    repeat (LAT + 10) tick();
  endtask

  task automatic test_reset();
    bus.tlp_valid = 0; bus.tlp_seq = 0; bus.tlp_crc_ok = 0; bus.dllp_ready = 1;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (bus.dllp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.dllp_valid); end
    checks++; if (bus.tlp_accept !== 1'b0) begin failures++; $display("FAIL reset_accept got=%0b exp=0", bus.tlp_accept); end
    checks++; if (bus.dllp_nak !== 1'b0 || bus.dllp_seq !== 12'd0) begin failures++; $display("FAIL reset_dllp nak=%0b seq=%0d exp 0/0", bus.dllp_nak, bus.dllp_seq); end
    checks++; if (nrs !== 12'd0) begin failures++; $display("FAIL reset_nrs got=%0d exp=0", nrs); end
  endtask

  task automatic test_coalesce();
    int acc = 0; bit f; int n;
    for (int i = 0; i < 4; i++) begin send(i, 1'b1); if (bus.tlp_accept) acc++; end
    checks++; if (acc != 4) begin failures++; $display("FAIL coal_accepts got=%0d exp=4", acc); end
    wait_dllp(5, f, n);
    checks++; if (!f || bus.dllp_nak !== 1'b0 || bus.dllp_seq !== 12'd3) begin failures++; $display("FAIL coal_ack found=%0b nak=%0b seq=%0d exp 1/0/3", f, bus.dllp_nak, bus.dllp_seq); end
    checks++; if (nrs !== 12'd4) begin failures++; $display("FAIL coal_nrs got=%0d exp=4", nrs); end
    tick();
  endtask

  task automatic test_nak();
    bit f; int n;
    send(4, 1'b1);
    send(5, 1'b0);
    wait_dllp(5, f, n);
    checks++; if (!f || bus.dllp_nak !== 1'b1 || bus.dllp_seq !== 12'd4) begin failures++; $display("FAIL nak_issue found=%0b nak=%0b seq=%0d exp 1/1/4", f, bus.dllp_nak, bus.dllp_seq); end
    tick();
    send(5, 1'b0);
    wait_dllp(20, f, n);
    checks++; if (f) begin failures++; $display("FAIL nak_once got dllp nak=%0b seq=%0d exp none", bus.dllp_nak, bus.dllp_seq); end
    send(5, 1'b1);
    checks++; if (bus.tlp_accept !== 1'b1 || nrs !== 12'd6) begin failures++; $display("FAIL nak_recover accept=%0b nrs=%0d exp 1/6", bus.tlp_accept, nrs); end
    repeat (LAT + 10) tick();
  endtask

  task automatic test_dup();
    bit f; int n;
    reset_and_fill(5);
    send(2, 1'b1);
    checks++; if (bus.tlp_accept !== 1'b0) begin failures++; $display("FAIL dup_accept got=%0b exp=0", bus.tlp_accept); end
    wait_dllp(5, f, n);
    checks++; if (!f || bus.dllp_nak !== 1'b0 || bus.dllp_seq !== 12'd4 || nrs !== 12'd5) begin failures++; $display("FAIL dup_ack found=%0b nak=%0b seq=%0d nrs=%0d exp 1/0/4/5", f, bus.dllp_nak, bus.dllp_seq, nrs); end
    tick();
  endtask

  task automatic test_ahead();
    bit f; int n;
    reset_and_fill(5);
    send(7, 1'b1);
    checks++; if (bus.tlp_accept !== 1'b0) begin failures++; $display("FAIL ahead_accept got=%0b exp=0", bus.tlp_accept); end
    wait_dllp(5, f, n);
    checks++; if (!f || bus.dllp_nak !== 1'b1 || bus.dllp_seq !== 12'd4 || nrs !== 12'd5) begin failures++; $display("FAIL ahead_nak found=%0b nak=%0b seq=%0d nrs=%0d exp 1/1/4/5", f, bus.dllp_nak, bus.dllp_seq, nrs); end
    tick();
  endtask

  task automatic test_wrap();
    bit f; int n;
    reset_and_fill(4095);
    checks++; if (nrs !== 12'd4095) begin failures++; $display("FAIL wrap_pre_nrs got=%0d exp=4095", nrs); end
    send(4095, 1'b1);
    checks++; if (bus.tlp_accept !== 1'b1 || nrs !== 12'd0) begin failures++; $display("FAIL wrap_nrs accept=%0b nrs=%0d exp 1/0", bus.tlp_accept, nrs); end
    wait_dllp(LAT + 10, f, n);
    checks++; if (!f || n != LAT || bus.dllp_nak !== 1'b0 || bus.dllp_seq !== 12'd4095) begin failures++; $display("FAIL wrap_latency_ack found=%0b cycles=%0d nak=%0b seq=%0d exp 1/%0d/0/4095", f, n, bus.dllp_nak, bus.dllp_seq, LAT); end
    tick();
    send(0, 1'b1);
    checks++; if (bus.tlp_accept !== 1'b1 || nrs !== 12'd1) begin failures++; $display("FAIL wrap_seq0 accept=%0b nrs=%0d exp 1/1", bus.tlp_accept, nrs); end
  endtask

  task automatic test_stall();
    bit f; int n;
    reset_and_fill(5);
    bus.dllp_ready = 1'b0;
    send(2, 1'b1);
    wait_dllp(5, f, n);
    checks++; if (!f) begin failures++; $display("FAIL stall_issue got=0 exp=1"); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) send(9, 1'b0); else tick();
      checks++;
      if (bus.dllp_valid !== 1'b1 || bus.dllp_nak !== 1'b0 || bus.dllp_seq !== 12'd4) begin
        failures++; $display("FAIL stall_hold cyc=%0d valid=%0b nak=%0b seq=%0d exp 1/0/4", i, bus.dllp_valid, bus.dllp_nak, bus.dllp_seq);
      end
    end
    bus.dllp_ready = 1'b1;
    tick();
    checks++; if (bus.dllp_valid !== 1'b0) begin failures++; $display("FAIL stall_release valid=%0b exp=0", bus.dllp_valid); end
    tick();
    checks++; if (bus.dllp_valid !== 1'b1 || bus.dllp_nak !== 1'b1 || bus.dllp_seq !== 12'd4) begin failures++; $display("FAIL stall_next_nak valid=%0b nak=%0b seq=%0d exp 1/1/4", bus.dllp_valid, bus.dllp_nak, bus.dllp_seq); end
    tick();
  endtask

  task automatic test_rst_hold();
    bit f; int n;
    reset_and_fill(5);
    bus.dllp_ready = 1'b0;
    send(2, 1'b1);
    wait_dllp(5, f, n);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (!f || bus.dllp_valid !== 1'b0 || nrs !== 12'd0) begin failures++; $display("FAIL rst_hold found=%0b valid=%0b nrs=%0d exp 1/0/0", f, bus.dllp_valid, nrs); end
    bus.dllp_ready = 1'b1;
  endtask

  task automatic test_random();
    int r; int bad = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bus.dllp_ready = ($urandom_range(0, 9) < 7);
      bus.tlp_valid  = ($urandom_range(0, 9) < 4);
      bus.tlp_crc_ok = ($urandom_range(0, 19) < 17);
      r = $urandom_range(0, 9);
      if (r < 6)      bus.tlp_seq = 12'(m_nrs);
      else if (r < 8) bus.tlp_seq = 12'(m_nrs - $urandom_range(1, 3));
      else            bus.tlp_seq = 12'($urandom);
      tick();
      checks++;
      if (bus.tlp_accept !== m_acc || nrs !== 12'(m_nrs) || bus.dllp_valid !== m_hold ||
          (m_hold && (bus.dllp_nak !== m_nak || bus.dllp_seq !== 12'(m_seq)))) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rand cyc=%0d acc=%0b/%0b nrs=%0d/%0d valid=%0b/%0b nak=%0b/%0b seq=%0d/%0d (got/exp)",
                   c, bus.tlp_accept, m_acc, nrs, m_nrs, bus.dllp_valid, m_hold, bus.dllp_nak, m_nak, bus.dllp_seq, m_seq);
      end
    end
    bus.tlp_valid = 1'b0; bus.dllp_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_coalesce();
    test_nak();
    test_dup();
    test_ahead();
    test_wrap();
    test_stall();
    test_rst_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
